// File: rtl/dp_bank_select_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_dec_pkg
// Shared definitions for the dual-port bank select arbiter:
//   - default address / bank-index widths
//   - conflict counter width (counter exists only with BANK_CONFLICT_CNT_EN)
//   - priority encoding for the round-robin bit
//   - onehot_of(): index -> one-hot helper used by both port decoders
// Ports: none (package).
// ---------------------------------------------------------------------------
package mem_dec_pkg;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_BANK_BITS  = 2;
  localparam int CONFLICT_CNT_W = 16;

  // onehot_of() works on a fixed maximum width; callers truncate to their
  // own bank count with a size cast.
  localparam int MAX_BANK_BITS  = 8;
  localparam int MAX_BANKS      = 2 ** MAX_BANK_BITS;

  // Which port wins the next same-bank collision.
  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  function automatic logic [MAX_BANKS-1:0] onehot_of(input logic [MAX_BANK_BITS-1:0] index);
    logic [MAX_BANKS-1:0] v;
    v        = '0;
    v[index] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dp_bank_select_arbiter_if.sv
// ---------------------------------------------------------------------------
// dp_bank_select_arbiter_if
// Bundles the two RAM-port requests and the registered arbiter results.
// Parameters: ADDR_W, BANK_BITS (NUM_BANKS and ROW_W are derived).
// Signals:
//   a_req/b_req, a_addr/b_addr            requester -> arbiter
//   a_gnt/b_gnt, a_bank_sel/b_bank_sel,
//   a_row/b_row, conflict                 arbiter -> requester
//   cnt_clr (in), conflict_cnt (out)      only with BANK_CONFLICT_CNT_EN
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface dp_bank_select_arbiter_if
  import mem_dec_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BANK_BITS = DEF_BANK_BITS
);

  localparam int NUM_BANKS = 2 ** BANK_BITS;
  localparam int ROW_W     = ADDR_W - BANK_BITS;

  logic                 a_req;
  logic [ADDR_W-1:0]    a_addr;
  logic                 b_req;
  logic [ADDR_W-1:0]    b_addr;
  logic                 a_gnt;
  logic                 b_gnt;
  logic [NUM_BANKS-1:0] a_bank_sel;
  logic [NUM_BANKS-1:0] b_bank_sel;
  logic [ROW_W-1:0]     a_row;
  logic [ROW_W-1:0]     b_row;
  logic                 conflict;
`ifdef BANK_CONFLICT_CNT_EN
  logic                      cnt_clr;
  logic [CONFLICT_CNT_W-1:0] conflict_cnt;
`endif

  modport master (
    output a_req, a_addr, b_req, b_addr,
`ifdef BANK_CONFLICT_CNT_EN
    output cnt_clr,
    input  conflict_cnt,
`endif
    input  a_gnt, b_gnt, a_bank_sel, b_bank_sel, a_row, b_row, conflict
  );

  modport slave (
    input  a_req, a_addr, b_req, b_addr,
`ifdef BANK_CONFLICT_CNT_EN
    input  cnt_clr,
    output conflict_cnt,
`endif
    output a_gnt, b_gnt, a_bank_sel, b_bank_sel, a_row, b_row, conflict
  );

endinterface

// File: rtl/dp_bank_select_arbiter_bank_onehot_decoder.sv
// ---------------------------------------------------------------------------
// bank_onehot_decoder
// Combinational bank-index to one-hot bank-enable decoder.
// Parameters: BANK_BITS (output width is 2**BANK_BITS).
// Ports:
//   i_bank    [BANK_BITS-1:0]     bank index
//   o_onehot  [2**BANK_BITS-1:0]  one-hot enable for that bank
// ---------------------------------------------------------------------------
module bank_onehot_decoder
  import mem_dec_pkg::*;
#(
  parameter int BANK_BITS = DEF_BANK_BITS
) (
  input  logic [BANK_BITS-1:0]      i_bank,
  output logic [(2**BANK_BITS)-1:0] o_onehot
);

  localparam int NUM_BANKS = 2 ** BANK_BITS;

  // Widen the index to the helper's width, then keep only our banks.
  assign o_onehot = NUM_BANKS'(onehot_of(MAX_BANK_BITS'(i_bank)));

endmodule

// File: rtl/dp_bank_select_arbiter.sv
// ---------------------------------------------------------------------------
// dp_bank_select_arbiter
// Registered dual-port bank decoder / arbiter. Decodes each port's bank
// field (top BANK_BITS of the address) into a one-hot bank enable, detects
// same-bank collisions and resolves them with a round-robin priority bit.
// All results are registered (one cycle latency).
// Parameters: ADDR_W, BANK_BITS (NUM_BANKS = 2**BANK_BITS, ROW_W derived).
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   bus   dp_bank_select_arbiter_if.slave
//         (a_req/a_addr/b_req/b_addr in; a_gnt/b_gnt, a_bank_sel/b_bank_sel,
//          a_row/b_row, conflict out)
// Optional feature macro: BANK_CONFLICT_CNT_EN adds bus.cnt_clr (in) and a
// saturating 16-bit collision counter on bus.conflict_cnt (out).
// ---------------------------------------------------------------------------
module dp_bank_select_arbiter
  import mem_dec_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BANK_BITS = DEF_BANK_BITS
) (
  input logic                     clk,
  input logic                     rst,
  dp_bank_select_arbiter_if.slave bus
);

  localparam int NUM_BANKS = 2 ** BANK_BITS;
  localparam int ROW_W     = ADDR_W - BANK_BITS;

  // A zero-width bank field, no row bits left, or more banks than the
  // one-hot helper covers are configuration errors.
  if (BANK_BITS < 1 || BANK_BITS >= ADDR_W || BANK_BITS > MAX_BANK_BITS) begin : g_bad_cfg
    $error("dp_bank_select_arbiter: illegal BANK_BITS=%0d for ADDR_W=%0d", BANK_BITS, ADDR_W);
  end

  logic [BANK_BITS-1:0] w_a_bank;
  logic [BANK_BITS-1:0] w_b_bank;
  logic [ROW_W-1:0]     w_a_row;
  logic [ROW_W-1:0]     w_b_row;
  logic [NUM_BANKS-1:0] w_a_onehot;
  logic [NUM_BANKS-1:0] w_b_onehot;
  logic                 w_collision;
  logic                 w_a_win;
  logic                 w_b_win;

  prio_e                r_prio;
  logic                 r_a_gnt;
  logic                 r_b_gnt;
  logic [NUM_BANKS-1:0] r_a_bank_sel;
  logic [NUM_BANKS-1:0] r_b_bank_sel;
  logic [ROW_W-1:0]     r_a_row;
  logic [ROW_W-1:0]     r_b_row;
  logic                 r_conflict;

  // Split each address into bank index and in-bank row.
  assign w_a_bank = bus.a_addr[ADDR_W-1 -: BANK_BITS];
  assign w_b_bank = bus.b_addr[ADDR_W-1 -: BANK_BITS];
  assign w_a_row  = bus.a_addr[ROW_W-1:0];
  assign w_b_row  = bus.b_addr[ROW_W-1:0];

  bank_onehot_decoder #(
    .BANK_BITS (BANK_BITS)
  ) u_a_dec (
    .i_bank   (w_a_bank),
    .o_onehot (w_a_onehot)
  );

  bank_onehot_decoder #(
    .BANK_BITS (BANK_BITS)
  ) u_b_dec (
    .i_bank   (w_b_bank),
    .o_onehot (w_b_onehot)
  );

  // Arbitration: a collision needs both requests on the same bank; then
  // only the port named by the priority bit wins. Otherwise every
  // requester wins.
  always_comb begin
    w_collision = bus.a_req && bus.b_req && (w_a_bank == w_b_bank);
    w_a_win     = bus.a_req && (!w_collision || (r_prio == PRIO_A));
    w_b_win     = bus.b_req && (!w_collision || (r_prio == PRIO_B));
  end

  // Output registers and priority state. Rows load only on a grant so the
  // memory sees a stable row while a port is idle or losing. The priority
  // flips only on a collision, handing the next one to this cycle's loser.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio       <= PRIO_A;
      r_a_gnt      <= 1'b0;
      r_b_gnt      <= 1'b0;
      r_a_bank_sel <= '0;
      r_b_bank_sel <= '0;
      r_a_row      <= '0;
      r_b_row      <= '0;
      r_conflict   <= 1'b0;
    end else begin
      r_a_gnt      <= w_a_win;
      r_b_gnt      <= w_b_win;
      r_a_bank_sel <= w_a_win ? w_a_onehot : '0;
      r_b_bank_sel <= w_b_win ? w_b_onehot : '0;
      r_conflict   <= w_collision;
      if (w_a_win) begin
        r_a_row <= w_a_row;
      end
      if (w_b_win) begin
        r_b_row <= w_b_row;
      end
      if (w_collision) begin
        r_prio <= (r_prio == PRIO_A) ? PRIO_B : PRIO_A;
      end
    end
  end

  assign bus.a_gnt      = r_a_gnt;
  assign bus.b_gnt      = r_b_gnt;
  assign bus.a_bank_sel = r_a_bank_sel;
  assign bus.b_bank_sel = r_b_bank_sel;
  assign bus.a_row      = r_a_row;
  assign bus.b_row      = r_b_row;
  assign bus.conflict   = r_conflict;

`ifdef BANK_CONFLICT_CNT_EN
  logic [CONFLICT_CNT_W-1:0] r_conflict_cnt;

  // Saturating collision counter; a clear in the same cycle as a collision
  // takes precedence over the increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= '0;
    end else if (bus.cnt_clr) begin
      r_conflict_cnt <= '0;
    end else if (w_collision && (r_conflict_cnt != '1)) begin
      r_conflict_cnt <= r_conflict_cnt + CONFLICT_CNT_W'(1);
    end
  end

  assign bus.conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_dp_bank_select_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dp_bank_select_arbiter
// Directed self-checking bench for dp_bank_select_arbiter at the default
// configuration (ADDR_W=8, BANK_BITS=2). Expected values are hand computed.
// Exercises the counter as well when BANK_CONFLICT_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_dp_bank_select_arbiter;
  import mem_dec_pkg::*;

  logic clk;
  logic rst;
  int   checkCount = 0;
  int   errorCount = 0;

  dp_bank_select_arbiter_if bus ();

  dp_bank_select_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on a miss counts the error and reports.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive both ports, let one rising edge sample them, then settle.
  task automatic applyStimulus(input logic aReq, input logic [7:0] aAddr,
                               input logic bReq, input logic [7:0] bAddr);
    bus.a_req  = aReq;
    bus.a_addr = aAddr;
    bus.b_req  = bReq;
    bus.b_addr = bAddr;
    @(posedge clk);
    #1;
  endtask

  // Compare every registered output against the expected set.
  task automatic checkPorts(input string step, input logic aGnt, input logic bGnt,
                            input logic [3:0] aSel, input logic [3:0] bSel,
                            input logic [5:0] aRow, input logic [5:0] bRow,
                            input logic conf);
    checkOutput({step, ".a_gnt"},      32'(bus.a_gnt),      32'(aGnt));
    checkOutput({step, ".b_gnt"},      32'(bus.b_gnt),      32'(bGnt));
    checkOutput({step, ".a_bank_sel"}, 32'(bus.a_bank_sel), 32'(aSel));
    checkOutput({step, ".b_bank_sel"}, 32'(bus.b_bank_sel), 32'(bSel));
    checkOutput({step, ".a_row"},      32'(bus.a_row),      32'(aRow));
    checkOutput({step, ".b_row"},      32'(bus.b_row),      32'(bRow));
    checkOutput({step, ".conflict"},   32'(bus.conflict),   32'(conf));
  endtask

  initial begin
    rst        = 1'b1;
    bus.a_req  = 1'b0;
    bus.a_addr = 8'h00;
    bus.b_req  = 1'b0;
    bus.b_addr = 8'h00;
`ifdef BANK_CONFLICT_CNT_EN
    bus.cnt_clr = 1'b0;
`endif

    // Reset held two cycles while both ports collide on bank 1.
    applyStimulus(1'b1, 8'h41, 1'b1, 8'h7F);
    applyStimulus(1'b1, 8'h41, 1'b1, 8'h7F);
    checkPorts("reset", 1'b0, 1'b0, 4'b0000, 4'b0000, 6'h00, 6'h00, 1'b0);
`ifdef BANK_CONFLICT_CNT_EN
    checkOutput("reset.conflict_cnt", 32'(bus.conflict_cnt), 32'd0);
`endif
    rst = 1'b0;

    // Held collision on bank 1: grants alternate A, B, A.
    applyStimulus(1'b1, 8'h41, 1'b1, 8'h7F);
    checkPorts("rr1", 1'b1, 1'b0, 4'b0010, 4'b0000, 6'h01, 6'h00, 1'b1);
    applyStimulus(1'b1, 8'h41, 1'b1, 8'h7F);
    checkPorts("rr2", 1'b0, 1'b1, 4'b0000, 4'b0010, 6'h01, 6'h3F, 1'b1);
    applyStimulus(1'b1, 8'h41, 1'b1, 8'h7F);
    checkPorts("rr3", 1'b1, 1'b0, 4'b0010, 4'b0000, 6'h01, 6'h3F, 1'b1);
`ifdef BANK_CONFLICT_CNT_EN
    checkOutput("rr3.conflict_cnt", 32'(bus.conflict_cnt), 32'd3);
`endif

    // Disjoint banks 0 and 3: both granted, no conflict (prio stays B).
    applyStimulus(1'b1, 8'h05, 1'b1, 8'hC3);
    checkPorts("disjoint", 1'b1, 1'b1, 4'b0001, 4'b1000, 6'h05, 6'h03, 1'b0);

    // B alone on bank 2; A row held.
    applyStimulus(1'b0, 8'h00, 1'b1, 8'h80);
    checkPorts("singleB", 1'b0, 1'b1, 4'b0000, 4'b0100, 6'h05, 6'h00, 1'b0);

    // Collision on bank 3: prio still favours B after non-collision cycles.
    applyStimulus(1'b1, 8'hC7, 1'b1, 8'hF0);
    checkPorts("prioHeldB", 1'b0, 1'b1, 4'b0000, 4'b1000, 6'h05, 6'h30, 1'b1);

    // Idle: everything drops, rows hold.
    applyStimulus(1'b0, 8'hFF, 1'b0, 8'hFF);
    checkPorts("idle", 1'b0, 1'b0, 4'b0000, 4'b0000, 6'h05, 6'h30, 1'b0);

    // A wins this collision, leaving prio favouring B.
    applyStimulus(1'b1, 8'h41, 1'b1, 8'h7F);
    checkPorts("preRst", 1'b1, 1'b0, 4'b0010, 4'b0000, 6'h01, 6'h30, 1'b1);

    // Reset during a collision beats the requests and restores prio to A.
    rst = 1'b1;
    applyStimulus(1'b1, 8'h41, 1'b1, 8'h7F);
    checkPorts("midRst", 1'b0, 1'b0, 4'b0000, 4'b0000, 6'h00, 6'h00, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 8'h41, 1'b1, 8'h7F);
    checkPorts("postRst", 1'b1, 1'b0, 4'b0010, 4'b0000, 6'h01, 6'h00, 1'b1);

    // A alone on bank 0 must not disturb prio (still favours B).
    applyStimulus(1'b1, 8'h3A, 1'b0, 8'h00);
    checkPorts("singleA", 1'b1, 1'b0, 4'b0001, 4'b0000, 6'h3A, 6'h00, 1'b0);
    applyStimulus(1'b1, 8'h0A, 1'b1, 8'h2B);
    checkPorts("prioHeldA", 1'b0, 1'b1, 4'b0000, 4'b0001, 6'h3A, 6'h2B, 1'b1);

`ifdef BANK_CONFLICT_CNT_EN
    // Counter restarted at the mid-run reset: postRst and prioHeldA.
    checkOutput("cnt.afterRst", 32'(bus.conflict_cnt), 32'd2);

    // Saturation after 70000 collision cycles.
    for (int i = 0; i < 70000; i++) begin
      applyStimulus(1'b1, 8'h41, 1'b1, 8'h7F);
    end
    checkOutput("cnt.saturate", 32'(bus.conflict_cnt), 32'h0000FFFF);

    // Clear during a collision wins over the increment.
    bus.cnt_clr = 1'b1;
    applyStimulus(1'b1, 8'h41, 1'b1, 8'h7F);
    checkOutput("cnt.clrWins", 32'(bus.conflict_cnt), 32'd0);
    bus.cnt_clr = 1'b0;
    applyStimulus(1'b1, 8'h41, 1'b1, 8'h7F);
    checkOutput("cnt.afterClr", 32'(bus.conflict_cnt), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
